// File: rtl/bulk_endp_sched_pkg.sv
// Shared types and helpers for the bulk endpoint scheduler.
// State encodings, data PID toggle values and index sizing.
package bulk_endp_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IN   = 2'd1,
      ST_OUT  = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   localparam logic DATA0 = 1'b0;
   localparam logic DATA1 = 1'b1;

   function automatic int ceil_log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/bulk_endp_sched_if.sv
// SIE-facing transaction handshake of the bulk endpoint scheduler.
// The SIE is the master; the scheduler is the slave.
interface bulk_endp_sched_if;

   logic [3:0] sie_endp_i;
   logic       sie_in_req_i;
   logic       sie_in_ready_i;
   logic [7:0] sie_in_data_o;
   logic       sie_in_valid_o;
   logic       sie_in_toggle_o;
   logic [7:0] sie_out_data_i;
   logic       sie_out_valid_i;
   logic       sie_out_toggle_i;
   logic       sie_out_err_i;
   logic       sie_out_ready_i;
   logic       sie_out_nak_o;
   logic       sie_stall_o;
   logic       sie_hit_o;

   modport master (
      output sie_endp_i, sie_in_req_i, sie_in_ready_i,
      output sie_out_data_i, sie_out_valid_i, sie_out_toggle_i,
      output sie_out_err_i, sie_out_ready_i,
      input  sie_in_data_o, sie_in_valid_o, sie_in_toggle_o,
      input  sie_out_nak_o, sie_stall_o, sie_hit_o
   );

   modport slave (
      input  sie_endp_i, sie_in_req_i, sie_in_ready_i,
      input  sie_out_data_i, sie_out_valid_i, sie_out_toggle_i,
      input  sie_out_err_i, sie_out_ready_i,
      output sie_in_data_o, sie_in_valid_o, sie_in_toggle_o,
      output sie_out_nak_o, sie_stall_o, sie_hit_o
   );

endinterface

// File: rtl/bulk_endp_sched_endp_status_regs.sv
// Per-endpoint DATA0/DATA1 toggles and halt bits.
// Config pulses take priority over transaction-driven toggle flips.
module endp_status_regs
   import bulk_endp_sched_pkg::*;
#(
   parameter int         N_ENDP    = 2,
   parameter logic [3:0] ENDP_BASE = 4'd1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              cfg_rst_i,
   input  logic              halt_set_i,
   input  logic              halt_clr_i,
   input  logic [3:0]        halt_endp_i,
   input  logic [N_ENDP-1:0] in_flip_i,
   input  logic [N_ENDP-1:0] out_flip_i,
   output logic [N_ENDP-1:0] in_tog_o,
   output logic [N_ENDP-1:0] out_tog_o,
   output logic [N_ENDP-1:0] halt_o
);

   localparam int IW = (ceil_log2(N_ENDP) > 1) ? ceil_log2(N_ENDP) : 1;
   localparam logic [4:0] N5 = 5'(N_ENDP);

   logic [3:0]    diff;
   logic          hit;
   logic [IW-1:0] idx;

   assign diff = halt_endp_i - ENDP_BASE;
   assign hit  = {1'b0, diff} < N5;
   assign idx  = diff[IW-1:0];

   // later assignments win: clear-halt overrides a same-cycle flip
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         in_tog_o  <= {N_ENDP{DATA0}};
         out_tog_o <= {N_ENDP{DATA0}};
         halt_o    <= '0;
      end else if (cfg_rst_i) begin
         in_tog_o  <= {N_ENDP{DATA0}};
         out_tog_o <= {N_ENDP{DATA0}};
         halt_o    <= '0;
      end else begin
         in_tog_o  <= in_tog_o ^ in_flip_i;
         out_tog_o <= out_tog_o ^ out_flip_i;
         if (hit && halt_set_i) begin
            halt_o[idx] <= 1'b1;
         end else if (hit && halt_clr_i) begin
            halt_o[idx]    <= 1'b0;
            in_tog_o[idx]  <= DATA0;
            out_tog_o[idx] <= DATA0;
         end
      end
   end

endmodule

// File: rtl/bulk_endp_sched.sv
// Steers SIE IN/OUT transactions to one of N_ENDP bulk endpoints.
// Owns per-endpoint toggle and halt state through endp_status_regs.
module bulk_endp_sched
   import bulk_endp_sched_pkg::*;
#(
   parameter int         N_ENDP    = 2,
   parameter logic [3:0] ENDP_BASE = 4'd1
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   bulk_endp_sched_if.slave    sie,
   output logic [N_ENDP-1:0]   endp_in_req_o,
   output logic [N_ENDP-1:0]   endp_in_ready_o,
   input  logic [8*N_ENDP-1:0] endp_in_data_i,
   input  logic [N_ENDP-1:0]   endp_in_valid_i,
   output logic [7:0]          endp_out_data_o,
   output logic [N_ENDP-1:0]   endp_out_valid_o,
   output logic [N_ENDP-1:0]   endp_out_err_o,
   output logic [N_ENDP-1:0]   endp_out_ready_o,
   input  logic [N_ENDP-1:0]   endp_out_nak_i,
   input  logic                halt_set_i,
   input  logic                halt_clr_i,
   input  logic [3:0]          halt_endp_i,
   input  logic                cfg_rst_i,
   output logic [N_ENDP-1:0]   halt_o
);

   localparam int IW = (ceil_log2(N_ENDP) > 1) ? ceil_log2(N_ENDP) : 1;
   localparam logic [4:0] N5 = 5'(N_ENDP);

   state_t        state_q, state_d;
   logic [IW-1:0] sel_q, sel_d, sel, idx;
   logic          stall_q, stall_d, stall_c;
   logic [3:0]    diff;
   logic          hit, in_go, out_go, ack, fin;
   logic [N_ENDP-1:0] in_flip, out_flip, in_tog, out_tog, halt;

   assign diff = sie.sie_endp_i - ENDP_BASE;
   assign hit  = {1'b0, diff} < N5;
   assign idx  = diff[IW-1:0];
   assign sel  = (state_q == ST_IDLE) ? idx : sel_q;

   assign sie.sie_hit_o = hit;
   assign endp_out_data_o = sie.sie_out_data_i;
   assign halt_o = halt;

   // a ready strobe with no data and no error ends the packet
   assign fin = sie.sie_out_ready_i && !sie.sie_out_valid_i &&
                !sie.sie_out_err_i;
   assign ack = fin;

   endp_status_regs #(
      .N_ENDP   (N_ENDP),
      .ENDP_BASE(ENDP_BASE)
   ) u_status (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .cfg_rst_i  (cfg_rst_i),
      .halt_set_i (halt_set_i),
      .halt_clr_i (halt_clr_i),
      .halt_endp_i(halt_endp_i),
      .in_flip_i  (in_flip),
      .out_flip_i (out_flip),
      .in_tog_o   (in_tog),
      .out_tog_o  (out_tog),
      .halt_o     (halt)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      stall_d  = stall_q;
      in_go    = 1'b0;
      out_go   = 1'b0;
      stall_c  = 1'b0;
      in_flip  = '0;
      out_flip = '0;
      endp_in_req_o    = '0;
      endp_in_ready_o  = '0;
      endp_out_valid_o = '0;
      endp_out_err_o   = '0;
      endp_out_ready_o = '0;
      sie.sie_in_data_o   = '0;
      sie.sie_in_valid_o  = 1'b0;
      sie.sie_in_toggle_o = 1'b0;
      sie.sie_out_nak_o   = 1'b0;
      sie.sie_stall_o     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (hit && sie.sie_in_req_i) begin
               state_d = ST_IN;
               sel_d   = idx;
               stall_d = halt[idx];
               stall_c = halt[idx];
               in_go   = 1'b1;
            end else if (hit && sie.sie_out_valid_i) begin
               sel_d = idx;
               if (halt[idx]) begin
                  state_d = ST_DROP;
                  stall_d = 1'b1;
                  sie.sie_stall_o = 1'b1;
               end else if (sie.sie_out_toggle_i != out_tog[idx]) begin
                  state_d = ST_DROP;
                  stall_d = 1'b0;
               end else begin
                  state_d = ST_OUT;
                  stall_d = 1'b0;
                  out_go  = 1'b1;
               end
            end
         end
         ST_IN: begin
            in_go   = 1'b1;
            stall_c = stall_q;
            if (!sie.sie_in_req_i) state_d = ST_IDLE;
            if (ack && !stall_q) begin
               in_flip[sel_q]          = 1'b1;
               endp_out_ready_o[sel_q] = 1'b1;
            end
         end
         ST_OUT: begin
            out_go = 1'b1;
            if (sie.sie_out_err_i) begin
               state_d = ST_IDLE;
            end else if (fin) begin
               state_d = ST_IDLE;
               out_flip[sel_q] = !endp_out_nak_i[sel_q];
            end
         end
         ST_DROP: begin
            sie.sie_stall_o = stall_q;
            if (sie.sie_out_err_i || fin) state_d = ST_IDLE;
         end
      endcase
      if (in_go) begin
         sie.sie_in_toggle_o = in_tog[sel];
         if (stall_c) begin
            sie.sie_stall_o = 1'b1;
         end else begin
            endp_in_req_o[sel]   = sie.sie_in_req_i;
            endp_in_ready_o[sel] = sie.sie_in_ready_i;
            sie.sie_in_data_o    = endp_in_data_i[{sel, 3'b000} +: 8];
            sie.sie_in_valid_o   = endp_in_valid_i[sel];
         end
      end
      if (out_go) begin
         endp_out_valid_o[sel] = sie.sie_out_valid_i;
         endp_out_err_o[sel]   = sie.sie_out_err_i;
         endp_out_ready_o[sel] = sie.sie_out_ready_i;
         sie.sie_out_nak_o     = endp_out_nak_i[sel];
      end
   end

endmodule

// File: tb/tb_bulk_endp_sched.sv
// Randomized scoreboard bench for bulk_endp_sched.
// Reference model tracks toggles and halts per endpoint.
module tb_bulk_endp_sched;

   localparam int N = 2;
   localparam int BASE = 1;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bulk_endp_sched_if sif();

   logic [N-1:0]   endp_in_req, endp_in_ready, endp_in_valid;
   logic [N-1:0]   endp_out_valid, endp_out_err, endp_out_ready;
   logic [N-1:0]   endp_out_nak, halt;
   logic [8*N-1:0] endp_in_data;
   logic [7:0]     endp_out_data;
   logic           halt_set, halt_clr, cfg_rst;
   logic [3:0]     halt_endp;

   bulk_endp_sched #(.N_ENDP(N), .ENDP_BASE(4'd1)) dut (
      .clk_i           (clk),
      .rstn_i          (rstn),
      .sie             (sif),
      .endp_in_req_o   (endp_in_req),
      .endp_in_ready_o (endp_in_ready),
      .endp_in_data_i  (endp_in_data),
      .endp_in_valid_i (endp_in_valid),
      .endp_out_data_o (endp_out_data),
      .endp_out_valid_o(endp_out_valid),
      .endp_out_err_o  (endp_out_err),
      .endp_out_ready_o(endp_out_ready),
      .endp_out_nak_i  (endp_out_nak),
      .halt_set_i      (halt_set),
      .halt_clr_i      (halt_clr),
      .halt_endp_i     (halt_endp),
      .cfg_rst_i       (cfg_rst),
      .halt_o          (halt)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0]  exp_in[$];
   logic [15:0] exp_out[$];
   int rdy_cnt[N];
   bit m_in[N], m_out[N], m_halt[N];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit mapped(input logic [3:0] ep);
      return int'(ep) >= BASE && int'(ep) < BASE + N;
   endfunction

   function automatic logic [N-1:0] hvec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_halt[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rstn) begin
         if (sif.sie_in_valid_o && sif.sie_in_ready_i) begin
            if (exp_in.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL in_data_unexpected: got %0h", sif.sie_in_data_o);
            end else begin
               chk("in_data", sif.sie_in_data_o, exp_in.pop_front());
            end
         end
         for (int i = 0; i < N; i++) begin
            if (endp_in_ready[i]) rdy_cnt[i]++;
            if (endp_out_valid[i]) begin
               if (exp_out.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL out_data_unexpected: ep idx %0d data %0h",
                           i, endp_out_data);
               end else begin
                  chk("out_data", {i[7:0], endp_out_data}, exp_out.pop_front());
               end
            end
         end
      end
   end

   task automatic do_in(input logic [3:0] ep, input int n, input bit ack);
      bit hit, st, fwd;
      int idx;
      logic [7:0] b;
      hit = mapped(ep);
      idx = hit ? int'(ep) - BASE : 0;
      st  = hit && m_halt[idx];
      fwd = hit && !st;
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
      sif.sie_endp_i = ep;
      sif.sie_in_req_i = 1'b1;
      for (int k = 0; k < n; k++) begin
         b = 8'($urandom);
         endp_in_data = (8*N)'($urandom);
         endp_in_data[8*idx +: 8] = b;
         endp_in_valid = '1;
         sif.sie_in_ready_i = 1'b1;
         if (fwd) exp_in.push_back(b);
         @(negedge clk);
         chk("in_hit", sif.sie_hit_o, hit);
         chk("in_stall", sif.sie_stall_o, st);
         chk("in_req_fwd", endp_in_req, fwd ? (1 << idx) : 0);
         if (fwd) chk("in_toggle", sif.sie_in_toggle_o, m_in[idx]);
         else chk("in_valid_blocked", sif.sie_in_valid_o, 0);
         if (!hit) chk("in_toggle_unmapped", sif.sie_in_toggle_o, 0);
         tick();
         sif.sie_in_ready_i = 1'b0;
         endp_in_valid = '0;
         tick();
      end
      if (ack) begin
         sif.sie_out_ready_i = 1'b1;
         @(negedge clk);
         chk("in_ack_fwd", endp_out_ready, fwd ? (1 << idx) : 0);
         if (fwd) m_in[idx] = !m_in[idx];
         tick();
         sif.sie_out_ready_i = 1'b0;
      end
      sif.sie_in_req_i = 1'b0;
      tick();
      for (int i = 0; i < N; i++)
         chk("in_ready_cnt", rdy_cnt[i], (fwd && i == idx) ? n : 0);
   endtask

   task automatic do_out(input logic [3:0] ep, input bit tog, input int n,
                         input logic [7:0] d0, input logic [N-1:0] nak,
                         input bit err);
      bit hit, st, acc;
      int idx;
      logic [7:0] d;
      hit = mapped(ep);
      idx = hit ? int'(ep) - BASE : 0;
      st  = hit && m_halt[idx];
      acc = hit && !st && (tog == m_out[idx]);
      endp_out_nak = nak;
      sif.sie_endp_i = ep;
      sif.sie_out_toggle_i = tog;
      for (int k = 0; k < n; k++) begin
         d = d0 + 8'(k * 17);
         sif.sie_out_data_i = d;
         sif.sie_out_valid_i = 1'b1;
         if (acc) exp_out.push_back({8'(idx), d});
         @(negedge clk);
         chk("out_hit", sif.sie_hit_o, hit);
         chk("out_stall", sif.sie_stall_o, st);
         chk("out_nak", sif.sie_out_nak_o, acc && nak[idx]);
         chk("out_data_pass", endp_out_data, d);
         tick();
         sif.sie_out_valid_i = 1'b0;
         tick();
      end
      if (err) sif.sie_out_err_i = 1'b1;
      else sif.sie_out_ready_i = 1'b1;
      @(negedge clk);
      if (err) chk("out_err_fwd", endp_out_err, acc ? (1 << idx) : 0);
      else chk("out_end_fwd", endp_out_ready, acc ? (1 << idx) : 0);
      if (acc && !err && !nak[idx]) m_out[idx] = !m_out[idx];
      tick();
      sif.sie_out_err_i = 1'b0;
      sif.sie_out_ready_i = 1'b0;
      endp_out_nak = '0;
      tick();
   endtask

   task automatic do_cfg(input bit c, input bit s, input bit cl,
                         input logic [3:0] ep);
      int idx;
      cfg_rst = c;
      halt_set = s;
      halt_clr = cl;
      halt_endp = ep;
      if (c) begin
         for (int i = 0; i < N; i++) begin
            m_halt[i] = 0; m_in[i] = 0; m_out[i] = 0;
         end
      end else if (mapped(ep)) begin
         idx = int'(ep) - BASE;
         if (s) m_halt[idx] = 1;
         else if (cl) begin
            m_halt[idx] = 0; m_in[idx] = 0; m_out[idx] = 0;
         end
      end
      tick();
      cfg_rst = 0;
      halt_set = 0;
      halt_clr = 0;
      @(negedge clk);
      chk("halt_o", halt, hvec());
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int op;
      logic [3:0] ep;
      bit tg;
      sif.sie_endp_i = 0;
      sif.sie_in_req_i = 0;
      sif.sie_in_ready_i = 0;
      sif.sie_out_data_i = 8'hA5;
      sif.sie_out_valid_i = 0;
      sif.sie_out_toggle_i = 0;
      sif.sie_out_err_i = 0;
      sif.sie_out_ready_i = 0;
      endp_in_data = '0;
      endp_in_valid = '0;
      endp_out_nak = '0;
      halt_set = 0;
      halt_clr = 0;
      halt_endp = 0;
      cfg_rst = 0;
      for (int i = 0; i < N; i++) begin
         m_in[i] = 0; m_out[i] = 0; m_halt[i] = 0; rdy_cnt[i] = 0;
      end
      #12;
      chk("rst_out_data_follow", endp_out_data, 8'hA5);
      chk("rst_halt", halt, 0);
      chk("rst_in_req", endp_in_req, 0);
      chk("rst_out_valid", endp_out_valid, 0);
      chk("rst_stall", sif.sie_stall_o, 0);
      chk("rst_in_valid", sif.sie_in_valid_o, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();

      // two acked INs to endpoint 1: toggles 0 then 1
      do_in(4'd1, 3, 1'b1);
      do_in(4'd1, 3, 1'b1);
      // OUT to endpoint 2, then a repeated DATA0 that must be dropped
      do_out(4'd2, 1'b0, 2, 8'h11, '0, 1'b0);
      do_out(4'd2, 1'b0, 2, 8'h11, '0, 1'b0);
      // NAKed OUT leaves toggle, next DATA0 still accepted
      do_out(4'd1, 1'b0, 2, 8'h40, 2'b01, 1'b0);
      do_out(4'd1, 1'b0, 1, 8'h50, '0, 1'b0);
      do_in(4'd1, 1, 1'b1);
      // halt, stalled IN, then clear restores DATA0
      do_cfg(0, 1, 0, 4'd1);
      do_in(4'd1, 2, 1'b1);
      do_out(4'd1, m_out[0], 1, 8'h60, '0, 1'b0);
      do_cfg(0, 0, 1, 4'd1);
      do_in(4'd1, 2, 1'b1);
      do_out(4'd1, 1'b0, 1, 8'h70, '0, 1'b0);
      // unmapped endpoint
      do_in(4'd5, 2, 1'b1);
      do_out(4'd5, 1'b0, 2, 8'h80, '0, 1'b0);
      // config precedence
      do_cfg(0, 1, 0, 4'd2);
      do_cfg(1, 1, 0, 4'd1);
      do_cfg(0, 1, 1, 4'd1);
      do_cfg(0, 0, 1, 4'd1);
      do_cfg(0, 1, 0, 4'd7);

      // reset in the middle of an OUT packet
      do_out(4'd2, m_out[1], 1, 8'h90, '0, 1'b0);
      sif.sie_endp_i = 4'd2;
      sif.sie_out_toggle_i = m_out[1];
      sif.sie_out_data_i = 8'h5A;
      sif.sie_out_valid_i = 1'b1;
      exp_out.push_back({8'd1, 8'h5A});
      @(negedge clk);
      tick();
      sif.sie_out_valid_i = 1'b0;
      #2;
      rstn = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_in[i] = 0; m_out[i] = 0; m_halt[i] = 0;
      end
      @(negedge clk);
      chk("midrst_out_valid", endp_out_valid, 0);
      chk("midrst_out_ready", endp_out_ready, 0);
      chk("midrst_stall", sif.sie_stall_o, 0);
      chk("midrst_halt", halt, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();
      do_out(4'd2, 1'b0, 2, 8'hC0, '0, 1'b0);
      do_in(4'd2, 1, 1'b1);

      // randomized traffic
      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 9);
         ep = 4'($urandom_range(0, 4));
         if (op <= 3) begin
            do_in(ep, $urandom_range(1, 4), $urandom_range(0, 3) != 0);
         end else if (op <= 7) begin
            tg = mapped(ep) ? m_out[int'(ep) - BASE] : 1'b0;
            if ($urandom_range(0, 3) == 0) tg = 1'($urandom);
            do_out(ep, tg, $urandom_range(1, 3), 8'($urandom),
                   N'($urandom) & N'($urandom),
                   $urandom_range(0, 7) == 0);
         end else if (op == 8) begin
            do_cfg(0, 1'($urandom), 1'($urandom), ep);
         end else begin
            do_cfg($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), ep);
         end
      end

      chk("in_queue_empty", exp_in.size(), 0);
      chk("out_queue_empty", exp_out.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bulk_endp_sched.md
Name: bulk_endp_sched

Overview:
Transaction scheduler between the SIE and N_ENDP bulk_endp instances. It decodes the token endpoint number and steers the SIE IN/OUT handshake to exactly one endpoint. It muxes data and NAK back to the SIE. It also owns per-endpoint DATA0/DATA1 toggle state and halt (STALL) state, which are configured by the control endpoint.

Parameters:
N_ENDP, 2, number of bulk endpoints served; legal range 1..15.
ENDP_BASE, 4'd1, USB endpoint number mapped to index 0; endpoint e maps to index e-ENDP_BASE.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  reset, asynchronous, active-low.
sie_endp_i  in  4  token endpoint number; stable from token until transaction end.
sie_in_req_i  in  1  IN transaction in progress.
sie_in_ready_i  in  1  IN byte consumed (1-cycle pulse).
sie_in_data_o  out  8  IN byte from selected endpoint.
sie_in_valid_o  out  1  IN byte valid.
sie_in_toggle_o  out  1  data PID to send (0=DATA0, 1=DATA1).
sie_out_data_i  in  8  OUT byte; broadcast to all endpoints.
sie_out_valid_i  in  1  OUT byte valid.
sie_out_toggle_i  in  1  data PID of the received OUT packet.
sie_out_err_i  in  1  OUT packet error.
sie_out_ready_i  in  1  OUT byte consumed / end-of-transaction strobe (1-cycle pulse).
sie_out_nak_o  out  1  NAK the current OUT.
sie_stall_o  out  1  answer STALL to the current transaction.
sie_hit_o  out  1  sie_endp_i is within the mapped range.
endp_in_req_o  out  N_ENDP  per-endpoint in_req.
endp_in_ready_o  out  N_ENDP  per-endpoint in_ready.
endp_in_data_i  in  8*N_ENDP  per-endpoint in_data; index i is at [8i+:8].
endp_in_valid_i  in  N_ENDP  per-endpoint in_valid.
endp_out_data_o  out  8  equals sie_out_data_i.
endp_out_valid_o  out  N_ENDP  per-endpoint out_valid.
endp_out_err_o  out  N_ENDP  per-endpoint out_err.
endp_out_ready_o  out  N_ENDP  per-endpoint out_ready.
endp_out_nak_i  in  N_ENDP  per-endpoint out_nak.
halt_set_i  in  1  pulse: halt endpoint halt_endp_i (SET_FEATURE ENDPOINT_HALT).
halt_clr_i  in  1  pulse: unhalt halt_endp_i and reset both of its toggles to DATA0.
halt_endp_i  in  4  USB endpoint number for halt_set_i/halt_clr_i.
cfg_rst_i  in  1  pulse: clear all halts and all toggles (SET_CONFIGURATION).
halt_o  out  N_ENDP  current halt bits.

Behaviour:
- States: ST_IDLE, ST_IN, ST_OUT, ST_DROP. Selected index sel = (state==ST_IDLE) ? sie_endp_i-ENDP_BASE : sel_q.
- Halt status is latched into stall_q at transaction start. A halt change during a transaction takes effect from the next transaction.
- Reset values: state=ST_IDLE, sel_q=0, stall_q=0, all toggles=0, all halts=0. All outputs 0 except endp_out_data_o, which follows sie_out_data_i.
- Unmapped endpoint (sie_hit_o=0): the FSM stays in ST_IDLE. All endp_* strobes and all sie_* outputs stay 0.
- ST_IDLE -> ST_IN: sie_in_req_i=1 with hit. Capture sel_q and stall_q=halt[sel].
- ST_IN forwarding (stall_q=0): endp_in_req_o[sel] = sie_in_req_i in the same cycle, including the first cycle in ST_IDLE. endp_in_ready_o[sel] = sie_in_ready_i. sie_in_data_o/sie_in_valid_o mux endpoint sel.
- ST_IN with stall_q=1: nothing is forwarded, sie_in_valid_o=0, sie_stall_o=1.
- sie_in_toggle_o = in_toggle[sel]. ACK in ST_IN (sie_out_ready_i=1, valid=0, err=0, stall_q=0) flips in_toggle[sel_q] and is forwarded as endp_out_ready_o[sel].
- ST_IN -> ST_IDLE when sie_in_req_i falls.
- ST_IDLE -> OUT decision on the first sie_out_valid_i=1 with hit: capture sel_q.
  - halt[sel]=1: go to ST_DROP, stall_q=1.
  - sie_out_toggle_i != out_toggle[sel]: go to ST_DROP, stall_q=0 (sequence error; the SIE ACKs and the data is discarded).
  - Otherwise: go to ST_OUT.
- ST_OUT: endp_out_valid_o/err/ready[sel_q] follow the SIE signals combinationally, and sie_out_nak_o = endp_out_nak_i[sel_q].
  - End strobe (ready=1, valid=0, err=0) with endp_out_nak_i[sel_q]=0 sampled that cycle flips out_toggle[sel_q]. Then -> ST_IDLE.
  - With err=1: -> ST_IDLE, toggle unchanged.
- ST_DROP: no endp_* strobes. sie_out_nak_o=0. sie_stall_o=stall_q. End or err -> ST_IDLE, toggle unchanged.
- Precedence among config pulses, same cycle: cfg_rst_i > halt_set_i > halt_clr_i. Toggle updates from config pulses override transaction-driven flips in the same cycle.
- halt_* pulses with an unmapped halt_endp_i are ignored.
- Width rule: index width is max(1, ceil_log2(N_ENDP)); the subtraction is performed on 4 bits.

Decomposition:
- Shared package: state encodings, PID toggle constants (DATA0=0, DATA1=1), ceil_log2 function.
- One natural sub-module: endp_status_regs. It holds the in_toggle/out_toggle/halt bit vectors, the config-pulse precedence and the flip strobes.

Test Plan:
1. Endpoint 1, two IN transactions of 3 bytes each, each ACKed. Required: first transaction sie_in_toggle_o=0, second =1; endp_in_ready_o[0] pulses exactly 3 times per transaction.
2. OUT to endpoint 2, DATA0, bytes 0x11/0x22, end strobe, endp_out_nak_i=0. Required: endp_out_valid_o[1] is seen with both bytes and out_toggle becomes 1. Repeat with DATA0: required ST_DROP, endp_out_valid_o stays 0, sie_out_nak_o=0, toggle stays 1.
3. OUT to endpoint 1 while endp_out_nak_i[0]=1. Required: sie_out_nak_o=1 and out_toggle unchanged at 0.
4. halt_set_i for endpoint 1, then IN. Required: sie_stall_o=1 and endp_in_req_o=0. Then halt_clr_i. Required: halt_o[0]=0, both toggles of endpoint 1 are 0, the next IN is served normally.
5. IN to endpoint 5 with N_ENDP=2. Required: sie_hit_o=0 and all endp_* outputs 0 throughout.
6. Assert rstn_i low mid-way through an OUT packet (after byte 1). Required: state ST_IDLE and all toggles 0. After release, a DATA0 OUT is accepted.
